// File: rtl/alu_pkg.sv
// Shared constants for the two-requester ALU arbiter: widths, opcode map, FSM encoding.
// Combinational helpers only; no latency or backpressure involved.
package alu_pkg;

  localparam int DW  = 32;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'd0;
  localparam logic [OPW-1:0] ALU_SUB = 4'd1;
  localparam logic [OPW-1:0] ALU_AND = 4'd2;
  localparam logic [OPW-1:0] ALU_OR  = 4'd3;
  localparam logic [OPW-1:0] ALU_XOR = 4'd4;
  localparam logic [OPW-1:0] ALU_NOR = 4'd5;
  localparam logic [OPW-1:0] ALU_SLL = 4'd6;
  localparam logic [OPW-1:0] ALU_SLT = 4'd7;
  localparam logic [OPW-1:0] ALU_SRL = 4'd8;

  localparam logic [OPW-1:0] MAX_OP = ALU_SRL;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the arbiter; slave = arbiter, master = requesters + ALU.
// Wiring only; all flow control lives in the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*DW-1:0]  req_a;
  logic [2*DW-1:0]  req_b;
  logic [2*OPW-1:0] req_op;

  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [DW-1:0]    rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;

  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [OPW-1:0]   alu_op;
  logic [DW-1:0]    alu_result;
  logic             alu_carry;
  logic             alu_zero;

  logic             busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
           alu_result, alu_carry, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
           alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
           alu_result, alu_carry, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
           alu_a, alu_b, alu_op, busy
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on a tie the one not served last wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_last,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  assign gnt_vld = |req_valid;

  always_comb begin
    case (req_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~rr_last;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between execute (0) and branch/address (1); response 2 cycles after accept, 1 for illegal op.
// Accepts only in IDLE; the response is held until the winner's rsp_ready, so one transaction is in flight at a time.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [1:0]     state;
  logic           rr_last;
  logic           win;
  logic           gnt_vld;
  logic           gnt_idx;
  logic           accept;
  logic [DW-1:0]  a_sel;
  logic [DW-1:0]  b_sel;
  logic [OPW-1:0] op_sel;

  rr_arb2 u_rr_arb2 (
    .req_valid (bus.req_valid),
    .rr_last   (rr_last),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  assign accept = (state == ST_IDLE) && gnt_vld;
  assign a_sel  = gnt_idx ? bus.req_a[2*DW-1:DW]   : bus.req_a[DW-1:0];
  assign b_sel  = gnt_idx ? bus.req_b[2*DW-1:DW]   : bus.req_b[DW-1:0];
  assign op_sel = gnt_idx ? bus.req_op[2*OPW-1:OPW] : bus.req_op[OPW-1:0];

  always_comb begin
    bus.req_ready = 2'b00;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_last        <= 1'b1;
      win            <= 1'b0;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            win <= gnt_idx;
            // Illegal opcodes bypass ISSUE so the ALU operand registers never see them.
            if (op_sel <= MAX_OP) begin
              bus.alu_a  <= a_sel;
              bus.alu_b  <= b_sel;
              bus.alu_op <= op_sel;
              state      <= ST_ISSUE;
            end else begin
              bus.rsp_err    <= 1'b1;
              bus.rsp_result <= '0;
              bus.rsp_carry  <= 1'b0;
              bus.rsp_zero   <= 1'b0;
              bus.rsp_valid  <= onehot2(gnt_idx);
              state          <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_carry  <= bus.alu_carry;
          bus.rsp_zero   <= bus.alu_zero;
          bus.rsp_err    <= 1'b0;
          bus.rsp_valid  <= onehot2(win);
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[win]) begin
            rr_last       <= win;
            bus.rsp_valid <= 2'b00;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level model of grants, latency and responses.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {carry, zero, result}
  function automatic logic [DW+1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OPW-1:0] op);
    logic [DW:0] w;
    w = '0;
    case (op)
      4'd0: w = {1'b0, a} + {1'b0, b};
      4'd1: w = {1'b0, a} - {1'b0, b};
      4'd2: w = {1'b0, a & b};
      4'd3: w = {1'b0, a | b};
      4'd4: w = {1'b0, a ^ b};
      4'd5: w = {1'b0, ~(a | b)};
      4'd6: w = {1'b0, a << b[4:0]};
      4'd7: w = {{DW{1'b0}}, ($signed(a) < $signed(b))};
      4'd8: w = {1'b0, a >> b[4:0]};
      default: w = '0;
    endcase
    return {w[DW], (w[DW-1:0] == '0), w[DW-1:0]};
  endfunction

  always_comb begin
    {bus.alu_carry, bus.alu_zero, bus.alu_result} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
  end

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
  } req_t;

  req_t rq [2][$];
  req_t cur [2];
  logic [1:0] acc;

  int n_vec, n_err;
  bit out_act, out_who, last;
  int out_k;
  req_t out_req;
  int cyc, n_acc, n_rsp;
  int acc_cyc [2];
  int hs_cyc [2];
  int gq [$];
  int rdy_mode, bp_left;
  bit gap_en;
  logic [DW-1:0] rsp_res_q;
  logic rsp_zero_q, rsp_err_q;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [OPW-1:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    rq[i].push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err,
              bus.alu_a, bus.alu_b, bus.alu_op, bus.busy}, '0);
  endtask

  // Observed at negedge: grant rule, busy, latency and response contents.
  task automatic sample();
    logic [1:0]     exp_g;
    logic [DW+1:0]  r;
    logic [DW+2:0]  exp_rsp;
    int             lat;
    bit             gi;
    cyc++;
    chk("busy", bus.busy, out_act);
    chk("alu_op_legal", bus.alu_op <= MAX_OP, 1);
    if (!out_act) begin
      chk("rsp_idle", bus.rsp_valid, 0);
      case (bus.req_valid)
        2'b00:   exp_g = 2'b00;
        2'b11:   exp_g = last ? 2'b01 : 2'b10;
        default: exp_g = bus.req_valid;
      endcase
      chk("req_ready", bus.req_ready, exp_g);
      if (exp_g != 2'b00) begin
        gi = exp_g[1];
        acc[gi] = 1'b1;
        out_act = 1; out_who = gi; out_k = 0; out_req = cur[gi];
        acc_cyc[gi] = cyc; gq.push_back(int'(gi)); n_acc++;
      end
    end else begin
      chk("req_ready_busy", bus.req_ready, 0);
      out_k++;
      lat = (out_req.op > 4'd8) ? 1 : 2;
      if (out_k == 1 && lat == 2)
        chk("alu_drive", {bus.alu_op, bus.alu_a, bus.alu_b}, {out_req.op, out_req.a, out_req.b});
      if (out_k < lat) begin
        chk("rsp_early", bus.rsp_valid, 0);
      end else begin
        chk("rsp_valid", bus.rsp_valid, out_who ? 2'b10 : 2'b01);
        if (lat == 1) exp_rsp = {1'b1, 2'b00, {DW{1'b0}}};
        else begin
          r = alu_ref(out_req.a, out_req.b, out_req.op);
          exp_rsp = {1'b0, r};
        end
        chk("rsp_data", {bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_result}, exp_rsp);
        if (bus.rsp_ready[out_who]) begin
          out_act = 0; last = out_who; hs_cyc[out_who] = cyc; n_rsp++;
          rsp_res_q = bus.rsp_result; rsp_zero_q = bus.rsp_zero; rsp_err_q = bus.rsp_err;
        end
      end
    end
  endtask

  // Driven just after posedge: requesters hold payload until accepted.
  task automatic update();
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        bus.req_valid[i] = 1'b0;
        acc[i] = 1'b0;
      end
      if (!bus.req_valid[i] && rq[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        cur[i] = rq[i].pop_front();
        bus.req_valid[i] = 1'b1;
        bus.req_a[i*DW +: DW]   = cur[i].a;
        bus.req_b[i*DW +: DW]   = cur[i].b;
        bus.req_op[i*OPW +: OPW] = cur[i].op;
      end
    end
    case (rdy_mode)
      1: bus.rsp_ready = 2'($urandom);
      2: begin
        bus.rsp_ready = 2'b11;
        if (bus.rsp_valid[0] && bp_left > 0) begin
          bus.rsp_ready[0] = 1'b0;
          bp_left--;
        end
      end
      default: bus.rsp_ready = 2'b11;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() != 0 || bus.req_valid != 2'b00 || out_act) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n >= budget, 0);
    chk("rsp_count", n_rsp, n_acc);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; n_acc = 0; n_rsp = 0;
    out_act = 0; out_who = 0; out_k = 0; last = 1; acc = 2'b00;
    gap_en = 0; rdy_mode = 0; bp_left = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    chk("reset_req_ready", bus.req_ready, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1; update();

    // Contention: strict alternation starting with requester 0
    gq.delete();
    for (int k = 0; k < 4; k++) begin
      push(0, 32'd10, 32'd5, ALU_AND);
      push(1, 32'd10, 32'd5, ALU_AND);
    end
    drain(200);
    chk("gnt_count", gq.size(), 8);
    for (int k = 0; k < 8; k++) chk("gnt_order", gq[k], k % 2);

    // Single add
    push(0, 32'd10, 32'd5, ALU_ADD);
    drain(50);
    chk("add_result", rsp_res_q, 15);
    chk("add_zero_err", {rsp_zero_q, rsp_err_q}, 0);
    chk("add_latency", hs_cyc[0] - acc_cyc[0], 2);

    // Illegal opcode
    push(1, 32'd7, 32'd9, 4'd12);
    drain(50);
    chk("ill_err", rsp_err_q, 1);
    chk("ill_result", rsp_res_q, 0);
    chk("ill_latency", hs_cyc[1] - acc_cyc[1], 1);

    // Backpressure on requester 0 with requester 1 pending
    rdy_mode = 2; bp_left = 5;
    push(0, 32'd100, 32'd23, ALU_SUB);
    cycle();
    push(1, 32'd3, 32'd4, ALU_OR);
    drain(100);
    chk("bp_hold", hs_cyc[0] - acc_cyc[0], 7);
    chk("bp_regrant", acc_cyc[1] - hs_cyc[0], 1);
    rdy_mode = 0;

    // Zero flag
    push(0, 32'd0, 32'd3, ALU_SRL);
    drain(50);
    chk("zero_set", {rsp_zero_q, rsp_res_q}, {1'b1, 32'd0});
    push(0, 32'd64, 32'd3, ALU_SRL);
    drain(50);
    chk("zero_clr", {rsp_zero_q, rsp_res_q}, {1'b0, 32'd8});

    // Random traffic with random response backpressure
    gap_en = 1; rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      push($urandom_range(0, 1),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
           4'($urandom_range(0, 15)));
    end
    drain(3000);
    gap_en = 0; rdy_mode = 0;

    // Asynchronous reset during ISSUE
    push(0, 32'd1, 32'd2, ALU_ADD);
    for (int k = 0; k < 10 && !out_act; k++) cycle();
    chk("mid_accepted", out_act, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    chk("rst_mid_ready", bus.req_ready, 0);
    if (out_act) n_acc--;
    out_act = 0; last = 1; acc = 2'b00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    gq.delete();
    push(0, 32'd5, 32'd6, ALU_XOR);
    push(1, 32'd7, 32'd8, ALU_AND);
    drain(100);
    chk("post_rst_first", gq[0], 0);
    chk("post_rst_second", gq[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
